// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-port signals shared by the arbiter.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_flush;
   logic        if_valid;
   logic [31:0] if_inst;
   logic        if_stall;
   logic [1:0]  d_load_type;
   logic [1:0]  d_store_type;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_valid;
   logic [63:0] d_rdata;
   logic        d_err;
   logic        d_stall;
   logic        m_req;
   logic        m_we;
   logic [1:0]  m_size;
   logic [63:0] m_addr;
   logic [63:0] m_wdata;
   logic        m_gnt;
   logic        m_rvalid;
   logic [63:0] m_rdata;
   modport slave (
      input  if_req, if_addr, if_flush, d_load_type, d_store_type, d_addr, d_wdata,
      input  m_gnt, m_rvalid, m_rdata,
      output if_valid, if_inst, if_stall, d_valid, d_rdata, d_err, d_stall,
      output m_req, m_we, m_size, m_addr, m_wdata
   );
   modport master (
      output if_req, if_addr, if_flush, d_load_type, d_store_type, d_addr, d_wdata,
      output m_gnt, m_rvalid, m_rdata,
      input  if_valid, if_inst, if_stall, d_valid, d_rdata, d_err, d_stall,
      input  m_req, m_we, m_size, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction at a time.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input logic clock,
   input logic reset_n,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, MISAL} state_t;
   state_t state, state_n;
   logic own_d, own_d_n, drop, drop_n, req, req_n, we, we_n;
   logic [1:0] size, size_n, d_size;
   logic [63:0] addr, addr_n, wdata, wdata_n;
   logic [CW-1:0] starve, starve_n;
   logic d_req, st, misal, sel_d, sel_f, rsp;
   // a store wins over a simultaneous load
   assign st = |bus.d_store_type;
   assign d_req = st || |bus.d_load_type;
   assign d_size = st ? bus.d_store_type : bus.d_load_type;
   assign misal = (d_size == 2'd2 && |bus.d_addr[1:0]) || (d_size == 2'd3 && |bus.d_addr[2:0]);
   assign sel_d = d_req && (starve < LIM || !bus.if_req);
   assign sel_f = !sel_d && bus.if_req;
   assign rsp = state == WAIT && bus.m_rvalid;
   assign bus.d_valid = (rsp && own_d) || state == MISAL;
   assign bus.d_err = state == MISAL;
   assign bus.d_rdata = state == MISAL ? '0 : bus.m_rdata;
   // a flush in the response cycle itself still kills the stale fetch
   assign bus.if_valid = rsp && !own_d && !drop && !bus.if_flush;
   assign bus.if_inst = bus.m_rdata[31:0];
   assign bus.if_stall = bus.if_req && !bus.if_valid;
   assign bus.d_stall = d_req && !bus.d_valid;
   assign bus.m_req = req;
   assign bus.m_we = we;
   assign bus.m_size = size;
   assign bus.m_addr = addr;
   assign bus.m_wdata = wdata;
   always_comb begin
      state_n = state;
      own_d_n = own_d;
      drop_n = drop;
      req_n = req;
      we_n = we;
      size_n = size;
      addr_n = addr;
      wdata_n = wdata;
      starve_n = starve;
      case (state)
         IDLE: begin
            drop_n = 1'b0;
            starve_n = (sel_d && bus.if_req) ? (starve == LIM ? starve : starve + 1'b1)
                     : (sel_f || !bus.if_req) ? '0 : starve;
            if (sel_d || sel_f) begin
               own_d_n = sel_d;
               state_n = (sel_d && misal) ? MISAL : REQ;
               req_n = !(sel_d && misal);
               we_n = sel_d && st;
               size_n = sel_d ? d_size : 2'd2;
               addr_n = sel_d ? bus.d_addr : bus.if_addr;
               wdata_n = (sel_d && st) ? bus.d_wdata : '0;
            end
         end
         REQ: begin
            drop_n = drop || (!own_d && bus.if_flush);
            state_n = bus.m_gnt ? WAIT : REQ;
            req_n = !bus.m_gnt;
         end
         WAIT: begin
            drop_n = (drop || (!own_d && bus.if_flush)) && !bus.m_rvalid;
            state_n = bus.m_rvalid ? IDLE : WAIT;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         own_d <= 1'b0;
         drop <= 1'b0;
         req <= 1'b0;
         we <= 1'b0;
         size <= '0;
         addr <= '0;
         wdata <= '0;
         starve <= '0;
      end else begin
         state <= state_n;
         own_d <= own_d_n;
         drop <= drop_n;
         req <= req_n;
         we <= we_n;
         size <= size_n;
         addr <= addr_n;
         wdata <= wdata_n;
         starve <= starve_n;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios against a transaction-level model checked every cycle.
module tb_mem_port_arbiter;
   localparam int LIMIT = 4;
   localparam logic [63:0] T3_EXP [7] = '{64'h20000, 64'h20008, 64'h20010, 64'h20018,
                                          64'h400080, 64'h20020, 64'h20028};
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int n_vec = 0;
   int n_bad = 0;
   int rvalid_delay = 0;
   int gnt_delay = 0;
   bit r_pend = 0;
   int r_cnt = 0;
   int r_gc = 0;
   bit r_g, r_f;
   logic [63:0] g_addr[$];
   logic [1:0] g_sz[$];
   logic g_we[$];
   logic [63:0] g_wd[$];
   logic [31:0] inst_a, inst_b;
   logic [63:0] rd_a;
   int stale_v;
   int n;

   mem_port_arbiter_if bus ();
   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   always #5 clock = ~clock;

   // model: one transaction record, its grant/response progress, and the fetch-starvation count
   bit act, isd, err, grd, stale, mw;
   logic [1:0] msz;
   logic [63:0] ma, mwd;
   int starve;
   wire dst = bus.d_store_type != 2'd0;
   wire dq = dst || bus.d_load_type != 2'd0;
   wire [1:0] dsz = dst ? bus.d_store_type : bus.d_load_type;
   wire bad = (dsz == 2'd2 && bus.d_addr[1:0] != 2'd0) || (dsz == 2'd3 && bus.d_addr[2:0] != 3'd0);
   wire take_d = dq && (starve < LIMIT || !bus.if_req);
   wire e_mreq = act && !err && !grd;
   wire e_dv = act && isd && (err || (grd && bus.m_rvalid));
   wire e_de = act && err;
   wire e_ifv = act && !isd && grd && bus.m_rvalid && !stale && !bus.if_flush;
   wire e_ifs = bus.if_req && !e_ifv;
   wire e_ds = dq && !e_dv;
   wire [63:0] e_drd = err ? 64'd0 : bus.m_rdata;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         act <= 0; isd <= 0; err <= 0; grd <= 0; stale <= 0; mw <= 0;
         msz <= 0; ma <= 0; mwd <= 0; starve <= 0;
      end else if (!act) begin
         stale <= 0;
         if (take_d) begin
            act <= 1; isd <= 1; err <= bad; grd <= 0;
            ma <= bus.d_addr; mw <= dst; msz <= dsz; mwd <= bus.d_wdata;
            starve <= bus.if_req ? (starve < LIMIT ? starve + 1 : LIMIT) : 0;
         end else if (bus.if_req) begin
            act <= 1; isd <= 0; err <= 0; grd <= 0;
            ma <= bus.if_addr; mw <= 0; msz <= 2'd2; starve <= 0;
         end else starve <= 0;
      end else if (err) act <= 0;
      else if (!grd) begin
         grd <= bus.m_gnt;
         if (!isd && bus.if_flush) stale <= 1;
      end else if (bus.m_rvalid) act <= 0;
      else if (!isd && bus.if_flush) stale <= 1;
   end

   task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
      n_vec++;
      if (act_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act_v, exp_v, $time);
      end
   endtask

   task automatic miss(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic do_fetch(input logic [63:0] a, output logic [31:0] inst);
      int k;
      bus.if_req = 1'b1;
      bus.if_addr = a;
      inst = '0;
      for (k = 0; k < 100; k++) begin
         @(negedge clock);
         if (bus.if_valid) break;
      end
      if (k == 100) miss("fetch_wait");
      else inst = bus.if_inst;
      step();
      bus.if_req = 1'b0;
   endtask

   task automatic do_data(input logic [1:0] lt, input logic [1:0] stt, input logic [63:0] a,
                          input logic [63:0] wd, output logic [63:0] rd);
      int k;
      bus.d_load_type = lt;
      bus.d_store_type = stt;
      bus.d_addr = a;
      bus.d_wdata = wd;
      rd = '0;
      for (k = 0; k < 100; k++) begin
         @(negedge clock);
         if (bus.d_valid) break;
      end
      if (k == 100) miss("data_wait");
      else rd = bus.d_rdata;
      step();
      bus.d_load_type = 2'd0;
      bus.d_store_type = 2'd0;
   endtask

   // memory: grants after gnt_delay cycles of m_req, answers rvalid_delay cycles after the grant
   initial begin
      bus.m_gnt = 1'b0;
      bus.m_rvalid = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         r_g = bus.m_gnt;
         r_f = bus.m_rvalid;
         if (r_f) r_pend = 0;
         if (r_g) begin
            r_pend = 1;
            r_cnt = rvalid_delay;
         end else if (r_pend && r_cnt > 0) r_cnt--;
         bus.m_rvalid = r_pend && r_cnt == 0;
         r_gc = bus.m_req ? r_gc + 1 : 0;
         bus.m_gnt = bus.m_req && r_gc > gnt_delay;
      end
   end

   initial forever begin
      @(negedge clock);
      if (reset_n && bus.m_req && bus.m_gnt) begin
         g_addr.push_back(bus.m_addr);
         g_sz.push_back(bus.m_size);
         g_we.push_back(bus.m_we);
         g_wd.push_back(bus.m_wdata);
      end
   end

   initial forever begin
      @(negedge clock);
      chk("m_req", 64'(bus.m_req), 64'(e_mreq));
      if (e_mreq) begin
         chk("m_addr", bus.m_addr, ma);
         chk("m_size", 64'(bus.m_size), 64'(msz));
         chk("m_we", 64'(bus.m_we), 64'(mw));
         if (mw) chk("m_wdata", bus.m_wdata, mwd);
      end
      chk("d_valid", 64'(bus.d_valid), 64'(e_dv));
      chk("d_err", 64'(bus.d_err), 64'(e_de));
      chk("if_valid", 64'(bus.if_valid), 64'(e_ifv));
      chk("if_stall", 64'(bus.if_stall), 64'(e_ifs));
      chk("d_stall", 64'(bus.d_stall), 64'(e_ds));
      if (e_dv) chk("d_rdata", bus.d_rdata, e_drd);
      if (e_ifv) chk("if_inst", 64'(bus.if_inst), 64'(bus.m_rdata[31:0]));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.if_req = 1'b0;
      bus.if_addr = '0;
      bus.if_flush = 1'b0;
      bus.d_load_type = 2'd0;
      bus.d_store_type = 2'd0;
      bus.d_addr = '0;
      bus.d_wdata = '0;
      bus.m_rdata = '0;
      @(negedge clock);
      chk("rst_m_req", 64'(bus.m_req), 64'd0);
      chk("rst_m_addr", bus.m_addr, 64'd0);
      chk("rst_m_size", 64'(bus.m_size), 64'd0);
      chk("rst_valids", 64'({bus.if_valid, bus.d_valid, bus.d_err}), 64'd0);
      step();
      reset_n = 1'b1;
      step();

      // fetch only, zero-wait memory
      bus.if_req = 1'b1;
      bus.if_addr = 64'h400000;
      bus.m_rdata = 64'h2408002A;
      @(negedge clock);
      chk("t1_c0_m_req", 64'(bus.m_req), 64'd0);
      chk("t1_c0_if_stall", 64'(bus.if_stall), 64'd1);
      step();
      @(negedge clock);
      chk("t1_c1_m_req", 64'(bus.m_req), 64'd1);
      chk("t1_c1_m_addr", bus.m_addr, 64'h400000);
      chk("t1_c1_m_size", 64'(bus.m_size), 64'd2);
      step();
      @(negedge clock);
      chk("t1_c2_if_valid", 64'(bus.if_valid), 64'd1);
      chk("t1_c2_if_inst", 64'(bus.if_inst), 64'h2408002A);
      step();
      bus.if_req = 1'b0;
      @(negedge clock);
      chk("t1_c3_if_stall", 64'(bus.if_stall), 64'd0);
      step();

      // store and fetch together: store goes first
      g_addr.delete(); g_sz.delete(); g_we.delete(); g_wd.delete();
      bus.m_rdata = 64'h0000_0000_1111_2222;
      fork
         do_fetch(64'h400040, inst_a);
         do_data(2'd0, 2'd3, 64'h10008, 64'hDEADBEEFCAFEF00D, rd_a);
      join
      chk("t2_ngrants", 64'(g_addr.size()), 64'd2);
      if (g_addr.size() == 2) begin
         chk("t2_store_we", 64'(g_we[0]), 64'd1);
         chk("t2_store_size", 64'(g_sz[0]), 64'd3);
         chk("t2_store_addr", g_addr[0], 64'h10008);
         chk("t2_store_wdata", g_wd[0], 64'hDEADBEEFCAFEF00D);
         chk("t2_fetch_addr", g_addr[1], 64'h400040);
         chk("t2_fetch_we", 64'(g_we[1]), 64'd0);
      end
      chk("t2_fetch_inst", 64'(inst_a), 64'h11112222);

      // continuous loads with fetch held: four data grants, one fetch, then data
      g_addr.delete(); g_sz.delete(); g_we.delete(); g_wd.delete();
      fork
         do_fetch(64'h400080, inst_a);
         for (int i = 0; i < 6; i++) do_data(2'd3, 2'd0, 64'h20000 + 64'(8 * i), 64'd0, rd_a);
      join
      chk("t3_ngrants", 64'(g_addr.size()), 64'd7);
      if (g_addr.size() == 7)
         for (int i = 0; i < 7; i++) begin
            chk("t3_order_addr", g_addr[i], T3_EXP[i]);
            chk("t3_order_size", 64'(g_sz[i]), i == 4 ? 64'd2 : 64'd3);
         end

      // redirect while a slow fetch is in flight
      rvalid_delay = 5;
      bus.m_rdata = 64'hBAD0BAD0;
      bus.if_req = 1'b1;
      bus.if_addr = 64'h400200;
      for (n = 0; n < 20; n++) begin
         @(negedge clock);
         if (bus.m_req && bus.m_gnt) break;
      end
      if (n == 20) miss("t4_first_grant");
      step();
      step();
      bus.if_flush = 1'b1;
      bus.if_addr = 64'h400300;
      @(negedge clock);
      chk("t4_stall_flush", 64'(bus.if_stall), 64'd1);
      step();
      bus.if_flush = 1'b0;
      stale_v = 0;
      for (n = 0; n < 40; n++) begin
         @(negedge clock);
         chk("t4_stall_hold", 64'(bus.if_stall), 64'd1);
         if (bus.if_valid) stale_v++;
         if (bus.m_req && bus.m_gnt) break;
      end
      if (n == 40) miss("t4_second_grant");
      chk("t4_no_stale_valid", 64'(stale_v), 64'd0);
      chk("t4_new_addr", bus.m_addr, 64'h400300);
      bus.m_rdata = 64'h20000001;
      for (n = 0; n < 40; n++) begin
         @(negedge clock);
         if (bus.if_valid) break;
         chk("t4_stall_wait", 64'(bus.if_stall), 64'd1);
      end
      if (n == 40) miss("t4_valid");
      chk("t4_inst", 64'(bus.if_inst), 64'h20000001);
      step();
      bus.if_req = 1'b0;
      rvalid_delay = 0;
      step();

      // misaligned word load, then an aligned byte load at an odd address
      bus.d_load_type = 2'd2;
      bus.d_addr = 64'h10002;
      @(negedge clock);
      chk("t5_c0_d_valid", 64'(bus.d_valid), 64'd0);
      step();
      @(negedge clock);
      chk("t5_c1_m_req", 64'(bus.m_req), 64'd0);
      chk("t5_c1_d_valid", 64'(bus.d_valid), 64'd1);
      chk("t5_c1_d_err", 64'(bus.d_err), 64'd1);
      chk("t5_c1_d_rdata", bus.d_rdata, 64'd0);
      step();
      bus.d_load_type = 2'd0;
      g_addr.delete(); g_sz.delete(); g_we.delete(); g_wd.delete();
      bus.m_rdata = 64'h00000000000000AB;
      do_data(2'd1, 2'd0, 64'h10003, 64'd0, rd_a);
      chk("t5_byte_ngrants", 64'(g_addr.size()), 64'd1);
      if (g_addr.size() == 1) begin
         chk("t5_byte_size", 64'(g_sz[0]), 64'd1);
         chk("t5_byte_addr", g_addr[0], 64'h10003);
      end
      chk("t5_byte_rdata", rd_a, 64'hAB);

      // asynchronous reset in WAIT, stray response afterwards
      rvalid_delay = 3;
      bus.m_rdata = 64'h5555;
      bus.if_req = 1'b1;
      bus.if_addr = 64'h400400;
      for (n = 0; n < 20; n++) begin
         @(negedge clock);
         if (bus.m_req && bus.m_gnt) break;
      end
      if (n == 20) miss("t6_grant");
      step();
      step();
      reset_n = 1'b0;
      bus.if_req = 1'b0;
      #1;
      chk("t6_rst_m_req", 64'(bus.m_req), 64'd0);
      chk("t6_rst_m_size", 64'(bus.m_size), 64'd0);
      chk("t6_rst_m_addr", bus.m_addr, 64'd0);
      chk("t6_rst_m_we_wdata", {63'd0, bus.m_we} | bus.m_wdata, 64'd0);
      chk("t6_rst_valids", 64'({bus.if_valid, bus.d_valid, bus.d_err}), 64'd0);
      step();
      reset_n = 1'b1;
      step();
      @(negedge clock);
      chk("t6_stray_if_valid", 64'(bus.if_valid), 64'd0);
      chk("t6_stray_d_valid", 64'(bus.d_valid), 64'd0);
      step();
      rvalid_delay = 0;
      bus.m_rdata = 64'h3C011234;
      do_fetch(64'h400500, inst_b);
      chk("t6_fresh_inst", 64'(inst_b), 64'h3C011234);
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares a single 64-bit memory port between the instruction fetch stage and the MEM-stage load/store unit of the 64-bit MIPS pipeline. It runs one outstanding transaction at a time, gives data accesses priority with a starvation guard for fetch, and drops fetch responses made stale by a pipeline redirect. It generates the per-stage stall signals that freeze the IF and MEM pipeline registers while their access is in flight.

## Interface
- STARVE_LIMIT, 4: max consecutive data grants while a fetch is waiting; after this many, the next grant goes to fetch.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  64  fetch address.
- if_flush  in  1  pipeline redirect (branch, jump, exception, ERET); the current fetch is stale.
- if_valid  out  1  fetch data valid.
- if_inst  out  32  fetched instruction, m_rdata[31:0].
- if_stall  out  1  if_req && !if_valid.
- d_load_type  in  2  0 none, 1 byte, 2 word, 3 dword.
- d_store_type  in  2  0 none, 1 byte, 2 word, 3 dword.
- d_addr  in  64  data address.
- d_wdata  in  64  store data, right-aligned.
- d_valid  out  1  load data valid or store complete.
- d_rdata  out  64  m_rdata passed unmodified; sign extension is done downstream.
- d_err  out  1  misaligned access; pulses together with d_valid.
- d_stall  out  1  data request pending && !d_valid.
- m_req  out  1  memory request; registered.
- m_we  out  1  write; registered.
- m_size  out  2  1 byte, 2 word, 3 dword; registered.
- m_addr  out  64  registered.
- m_wdata  out  64  registered.
- m_gnt  in  1  memory accepts the request this cycle.
- m_rvalid  in  1  read data or write ack.
- m_rdata  in  64  read data.

## Operation
- Data request: d_load_type != 0 or d_store_type != 0. If both fields are nonzero, the store wins and the load is ignored.
- State machine:
  - IDLE: samples requests.
  - REQ: m_req is high, waiting for m_gnt.
  - WAIT: waiting for m_rvalid.
  - MISAL: single-cycle error reply.
- Arbitration in IDLE:
  - Data is chosen if a data request is present and (starve_cnt < STARVE_LIMIT or !if_req).
  - Otherwise fetch is chosen if if_req.
  - Otherwise the block stays in IDLE.
- On selection, the block latches owner, m_addr, m_we, m_size and m_wdata, then moves to REQ.
  - Fetch uses m_size=2 and m_we=0.
  - Store uses m_we=1 and m_wdata=d_wdata.
- Misaligned data access (word with addr[1:0] != 0, or dword with addr[2:0] != 0): the block goes to MISAL instead of REQ. No m_req is raised. The next cycle gives d_valid=1, d_err=1, d_rdata=0, then IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data selection made while if_req=1.
  - Clears on fetch selection, or on any IDLE cycle with if_req=0.
- REQ to WAIT on m_gnt. m_req and all m_* fields stay stable until the grant; m_req drops the cycle after the grant.
- WAIT to IDLE on m_rvalid:
  - Owner data: d_valid=1, combinational from m_rvalid.
  - Owner fetch and drop=0: if_valid=1.
  - Owner fetch and drop=1: response discarded, no valid.
- drop flag:
  - Set by if_flush while owner=fetch in REQ or WAIT, including the m_rvalid cycle itself.
  - Cleared on return to IDLE.
  - if_flush in IDLE has no effect.
- A granted transaction is never withdrawn. Flush only suppresses the response.
- if_req or data-request deassertion after selection does not cancel the transaction.
- m_rvalid in IDLE or REQ is ignored.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - State IDLE; m_req, m_we, m_size, m_addr, m_wdata, starve_cnt and drop all 0.
  - if_valid, d_valid and d_err are 0.
  - A memory response arriving after reset is ignored.
- Minimum latency with zero-wait memory:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: m_req=1 and m_gnt=1.
  - Cycle 2: m_rvalid, so d_valid/if_valid=1.
  - Cycle 3: IDLE, re-arbitrate.
  - Peak throughput is one access per 3 cycles.
- Misaligned reply latency: d_valid+d_err one cycle after the IDLE sample.
- if_stall and d_stall are combinational. The requesting stage advances on the edge ending its valid cycle.
- Drop while the memory is slow: if_stall stays high until the stale response returns. Arbitration then restarts and the new if_addr is fetched.

## Test plan
- Fetch-only, zero-wait memory, if_addr=0x400000, m_rdata=0x2408002A -> m_req in cycle 1 with m_addr=0x400000 and m_size=2; if_valid=1 with if_inst=0x2408002A in cycle 2; if_stall low from cycle 3.
- Simultaneous if_req and store dword to 0x10008 with d_wdata=0xDEADBEEFCAFEF00D -> store issued first with m_we=1, m_size=3, m_wdata as given; fetch issued after the store's m_rvalid.
- Continuous data requests with if_req held and STARVE_LIMIT=4 -> exactly 4 data transactions, then one fetch, then data again.
- Fetch granted, m_rvalid delayed 5 cycles, if_flush pulsed in WAIT -> no if_valid for the stale access; the next fetch uses the new if_addr; if_stall held high throughout.
- Load word at 0x10002 -> no m_req; d_valid=1, d_err=1, d_rdata=0 one cycle later. Load byte at 0x10003 -> normal access with m_size=1.
- reset_n low while in WAIT with m_rvalid arriving 2 cycles later -> all outputs 0 immediately; stray m_rvalid ignored; a fresh request afterwards completes normally.
